// File: rtl/ifu_thr_fetch_sched.sv
// Four-thread round-robin fetch scheduler with per-thread fetch PC file.
// Selection is registered; pc_f and fetch_kill_f are combinational on the registered state.
module ifu_thr_fetch_sched #(
    parameter int unsigned     PC_W   = 48,
    parameter logic [PC_W-1:0] RST_PC = 48'h0000_FFF0_0020,
    parameter int unsigned     PC_INC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      thr_rdy_s,
    input  logic [3:0]      imiss_wait,
    input  logic            stall_f,
    input  logic            redirect_vld,
    input  logic [1:0]      redirect_tid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [3:0]      thr_f,
    output logic [3:0]      pc_sel_f,
    output logic            inst_vld_f,
    output logic [PC_W-1:0] pc_f,
    output logic [PC_W-1:0] t0pc_f,
    output logic [PC_W-1:0] t1pc_f,
    output logic [PC_W-1:0] t2pc_f,
    output logic [PC_W-1:0] t3pc_f,
    output logic            fetch_kill_f
);

    logic [3:0]      eligible;
    logic [1:0]      last_tid;
    logic [1:0]      win;
    logic [1:0]      idx;
    logic            any_elig;
    logic [PC_W-1:0] pc_q [4];

    assign eligible = thr_rdy_s & ~imiss_wait;

    // Search starts one past the last winner, so the last winner is tried last.
    always_comb begin
        any_elig = 1'b0;
        win      = last_tid;
        idx      = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_tid + 2'(k);
            if (!any_elig && eligible[idx]) begin
                any_elig = 1'b1;
                win      = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_f      <= 4'b0000;
            inst_vld_f <= 1'b0;
            last_tid   <= 2'd3;
        end else if (!stall_f) begin
            if (any_elig) begin
                thr_f      <= 4'b0001 << win;
                inst_vld_f <= 1'b1;
                last_tid   <= win;
            end else begin
                thr_f      <= 4'b0000;
                inst_vld_f <= 1'b0;
            end
        end
    end

    // A redirect overrides the advance of a fetch it kills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) pc_q[n] <= RST_PC;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (redirect_vld && redirect_tid == 2'(n))
                    pc_q[n] <= redirect_pc & ~PC_W'(3);
                else if (inst_vld_f && thr_f[n] && !stall_f)
                    pc_q[n] <= pc_q[n] + PC_W'(PC_INC);
            end
        end
    end

    always_comb begin
        pc_f = '0;
        for (int n = 0; n < 4; n++)
            if (thr_f[n]) pc_f = pc_q[n];
    end

    assign pc_sel_f     = thr_f;
    assign fetch_kill_f = redirect_vld & inst_vld_f & thr_f[redirect_tid];
    assign t0pc_f       = pc_q[0];
    assign t1pc_f       = pc_q[1];
    assign t2pc_f       = pc_q[2];
    assign t3pc_f       = pc_q[3];

endmodule
